// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the PWM bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pwm_pkg;

  // Default timing width; modules carry their own WIDTH parameter.
  localparam int PWM_WIDTH = 8;

  // One channel's timing pair at the default width.
  typedef struct packed {
    logic [PWM_WIDTH-1:0] off_cyc;
    logic [PWM_WIDTH-1:0] on_cyc;
  } pwm_timing_t;

  // Reset timing: OFF=1, ON=0 parks a channel in the constant-low mode.
  localparam int PWM_RST_OFF = 1;
  localparam int PWM_RST_ON  = 0;

endpackage

// File: rtl/pwm_bank_ch.sv
// One PWM channel: active/shadow timing, pending flag, phase counter and output decode.
// Latency: a write lands in the shadow next edge; it reaches the active timing at the next period boundary.
// Backpressure: none; writes are always accepted and later writes overwrite earlier ones.
// Optional: PWM_BANK_POLARITY_EN adds pol_i, XORed onto out_o last.
module pwm_bank_ch
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_off_i,
  input  logic [WIDTH-1:0] wr_on_i,
`ifdef PWM_BANK_POLARITY_EN
  input  logic             pol_i,
`endif
  output logic             out_o,
  output logic             done_o,
  output logic             pend_o
);

  logic [WIDTH-1:0] act_off_q, act_off_d;
  logic [WIDTH-1:0] act_on_q, act_on_d;
  logic [WIDTH-1:0] sh_off_q, sh_off_d;
  logic [WIDTH-1:0] sh_on_q, sh_on_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             ph_q, ph_d;

  logic             timed;
  logic             running;
  logic             boundary;
  logic             apply;
  logic [WIDTH-1:0] limit;
  logic             raw_out;

  // Both phases non-zero means the counter actually runs.
  assign timed    = (act_off_q != '0) && (act_on_q != '0);
  assign running  = en_i && timed;
  assign limit    = ph_q ? act_on_q : act_off_q;
  assign boundary = running && ph_q && (cnt_q == act_on_q - WIDTH'(1));
  // Disabled and degenerate channels treat every cycle as a boundary.
  assign apply    = !running || boundary;

  // Output decode: disabled low, OFF=0 forces high, ON=0 forces low, else phase.
  always_comb begin
    raw_out = 1'b0;
    if (!en_i)                 raw_out = 1'b0;
    else if (act_off_q == '0)  raw_out = 1'b1;
    else if (act_on_q == '0)   raw_out = 1'b0;
    else                       raw_out = ph_q;
  end

`ifdef PWM_BANK_POLARITY_EN
  assign out_o = raw_out ^ pol_i;
`else
  assign out_o = raw_out;
`endif
  assign done_o = boundary;
  assign pend_o = pend_q;

  // Timing update: a write at an apply point bypasses straight to active.
  always_comb begin
    act_off_d = act_off_q;
    act_on_d  = act_on_q;
    sh_off_d  = sh_off_q;
    sh_on_d   = sh_on_q;
    pend_d    = pend_q;
    if (wr_i) begin
      sh_off_d = wr_off_i;
      sh_on_d  = wr_on_i;
      if (apply) begin
        act_off_d = wr_off_i;
        act_on_d  = wr_on_i;
        pend_d    = 1'b0;
      end else begin
        pend_d    = 1'b1;
      end
    end else if (apply && pend_q) begin
      act_off_d = sh_off_q;
      act_on_d  = sh_on_q;
      pend_d    = 1'b0;
    end
  end

  // Phase counter: wraps at the end of each phase, held at zero when not running.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    ph_d  = ph_q;
    if (!running) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (cnt_q == limit - WIDTH'(1)) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_off_q <= WIDTH'(PWM_RST_OFF);
      act_on_q  <= WIDTH'(PWM_RST_ON);
      sh_off_q  <= '0;
      sh_on_q   <= '0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      ph_q      <= 1'b0;
    end else begin
      act_off_q <= act_off_d;
      act_on_q  <= act_on_d;
      sh_off_q  <= sh_off_d;
      sh_on_q   <= sh_on_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with glitch-free double-buffered timing updates.
// Latency: outputs are combinational from channel state; timing changes apply at the next period boundary.
// Backpressure: none; out-of-range wr_ch writes are dropped.
// Optional: PWM_BANK_POLARITY_EN adds the per-channel pol input.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_off,
  input  logic [WIDTH-1:0]  wr_on,
  input  logic [NUM_CH-1:0] en,
`ifdef PWM_BANK_POLARITY_EN
  input  logic [NUM_CH-1:0] pol,
`endif
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] period_done,
  output logic [NUM_CH-1:0] pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_wr;

    // Write decode: an index at or beyond NUM_CH matches no channel.
    assign ch_wr = wr_en && (wr_ch == CH_W'(i));

    pwm_bank_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en[i]),
      .wr_i     (ch_wr),
      .wr_off_i (wr_off),
      .wr_on_i  (wr_on),
`ifdef PWM_BANK_POLARITY_EN
      .pol_i    (pol[i]),
`endif
      .out_o    (out[i]),
      .done_o   (period_done[i]),
      .pend_o   (pending[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank (3 channels so wr_ch=3 is an invalid index).
module tb_pwm_bank;

  localparam int NCH = 3;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [W-1:0]   wr_off;
  logic [W-1:0]   wr_on;
  logic [NCH-1:0] en;
`ifdef PWM_BANK_POLARITY_EN
  logic [NCH-1:0] pol = '0;
`endif
  logic [NCH-1:0] out;
  logic [NCH-1:0] period_done;
  logic [NCH-1:0] pending;

  typedef struct {
    string          tag;
    logic [NCH-1:0] m;
    logic [NCH-1:0] o;
    logic [NCH-1:0] pd;
    logic [NCH-1:0] pn;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pwm_bank #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_off      (wr_off),
    .wr_on       (wr_on),
    .en          (en),
`ifdef PWM_BANK_POLARITY_EN
    .pol         (pol),
`endif
    .out         (out),
    .period_done (period_done),
    .pending     (pending)
  );

  // Expected waveform of a running channel: OFF phase first, done on last ON cycle.
  function automatic logic pat_out(int off, int on, int k);
    return (k % (off + on)) >= off;
  endfunction
  function automatic logic pat_done(int off, int on, int k);
    return (k % (off + on)) == (off + on - 1);
  endfunction

  task automatic push(string tag, logic [NCH-1:0] m, logic [NCH-1:0] o,
                      logic [NCH-1:0] pd, logic [NCH-1:0] pn);
    exp_t e;
    e.tag = tag; e.m = m; e.o = o; e.pd = pd; e.pn = pn;
    exp_q.push_back(e);
  endtask

  task automatic push_n(string tag, int n, logic [NCH-1:0] m, logic [NCH-1:0] o);
    for (int i = 0; i < n; i++) push(tag, m, o, '0, '0);
  endtask

  task automatic push_cyc(string tag, int ch, int off, int on, int k, logic pn);
    logic [NCH-1:0] m;
    m = NCH'(1) << ch;
    push(tag, m, pat_out(off, on, k) ? m : '0, pat_done(off, on, k) ? m : '0, pn ? m : '0);
  endtask

  task automatic push_pat(string tag, int ch, int off, int on, int periods);
    for (int k = 0; k < periods * (off + on); k++) push_cyc(tag, ch, off, on, k, 1'b0);
  endtask

  // All three channels at cycle k: ch0 3/2, ch1 1/1, ch2 2/1.
  task automatic push_all(string tag, int k, logic [NCH-1:0] pn);
    logic [NCH-1:0] o, pd;
    o  = {pat_out(2, 1, k),  pat_out(1, 1, k),  pat_out(3, 2, k)};
    pd = {pat_done(2, 1, k), pat_done(1, 1, k), pat_done(3, 2, k)};
    push(tag, '1, o, pd, pn);
  endtask

  task automatic check_now();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected>=1 entries");
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert ((out & e.m) === (e.o & e.m)) else begin
        errors++;
        $error("FAIL %s out observed=%b expected=%b", e.tag, out & e.m, e.o & e.m);
      end
      checks++;
      assert ((period_done & e.m) === (e.pd & e.m)) else begin
        errors++;
        $error("FAIL %s period_done observed=%b expected=%b", e.tag, period_done & e.m, e.pd & e.m);
      end
      checks++;
      assert ((pending & e.m) === (e.pn & e.m)) else begin
        errors++;
        $error("FAIL %s pending observed=%b expected=%b", e.tag, pending & e.m, e.pn & e.m);
      end
    end
  endtask

  task automatic check_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_now();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(int ch, int off, int on);
    wr_en  = 1'b1;
    wr_ch  = 2'(ch);
    wr_off = W'(off);
    wr_on  = W'(on);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_off = '0; wr_on = '0; en = '0;
    #2;
    push("reset", '1, '0, '0, '0);
    check_now();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset timing with enable high stays low for 50 cycles.
    en = '1;
    push_n("idle_enabled", 50, '1, '0);
    check_cycles(50);

    // ch0 programmed 3/2 while disabled, then enabled.
    en = '0;
    push_n("disable_all", 1, '1, '0);
    check_cycles(1);
    wr(0, 3, 2);
    push_n("wr_disabled", 1, 3'b001, '0);
    check_cycles(1);
    wr_en = 1'b0;
    en = 3'b001;
    push_pat("ch0_3_2", 0, 3, 2, 3);
    check_cycles(15);

    // Mid-OFF update to 1/4 waits for the boundary.
    push_cyc("ch0_pre_upd", 0, 3, 2, 0, 1'b0);
    check_cycles(1);
    wr(0, 1, 4);
    push_cyc("ch0_upd_wr", 0, 3, 2, 1, 1'b0);
    check_cycles(1);
    wr_en = 1'b0;
    for (int k = 2; k < 5; k++) push_cyc("ch0_upd_pend", 0, 3, 2, k, 1'b1);
    check_cycles(3);
    push_pat("ch0_1_4", 0, 1, 4, 2);
    check_cycles(10);

    // ch1: write landing exactly on the period_done cycle bypasses the shadow.
    wr(1, 2, 2);
    push_n("ch1_wr_dis", 1, 3'b010, '0);
    check_cycles(1);
    wr_en = 1'b0;
    en = 3'b011;
    push_pat("ch1_2_2", 1, 2, 2, 1);
    for (int k = 0; k < 3; k++) push_cyc("ch1_2_2b", 1, 2, 2, k, 1'b0);
    check_cycles(7);
    wr(1, 1, 1);
    push_cyc("ch1_bypass_wr", 1, 2, 2, 3, 1'b0);
    check_cycles(1);
    wr_en = 1'b0;
    push_pat("ch1_1_1", 1, 1, 1, 2);
    check_cycles(4);

    // ch2: two writes before a boundary, last one wins.
    wr(2, 3, 2);
    push_n("ch2_wr_dis", 1, 3'b100, '0);
    check_cycles(1);
    en = 3'b111;
    wr(2, 5, 5);
    push_cyc("ch2_wr_a", 2, 3, 2, 0, 1'b0);
    check_cycles(1);
    wr(2, 2, 1);
    push_cyc("ch2_wr_b", 2, 3, 2, 1, 1'b1);
    check_cycles(1);
    wr_en = 1'b0;
    for (int k = 2; k < 5; k++) push_cyc("ch2_pend", 2, 3, 2, k, 1'b1);
    check_cycles(3);
    push_pat("ch2_2_1", 2, 2, 1, 2);
    check_cycles(6);

    // ch0 degenerate modes; pending applies on the next edge.
    en = 3'b110;
    push_n("ch0_off", 1, 3'b001, '0);
    check_cycles(1);
    wr(0, 0, 5);
    push_n("ch0_wr_0_5", 1, 3'b001, '0);
    check_cycles(1);
    wr_en = 1'b0;
    en = 3'b111;
    push_n("ch0_const_hi", 10, 3'b001, 3'b001);
    check_cycles(10);
    wr(0, 4, 0);
    push_n("ch0_wr_4_0", 1, 3'b001, 3'b001);
    check_cycles(1);
    wr_en = 1'b0;
    push_n("ch0_const_lo", 10, 3'b001, '0);
    check_cycles(10);

    // Enable drop mid-ON, then restart from the OFF phase.
    wr(0, 3, 2);
    push_n("ch0_wr_3_2", 1, 3'b001, '0);
    check_cycles(1);
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) push_cyc("ch0_run", 0, 3, 2, k, 1'b0);
    check_cycles(4);
    en = 3'b110;
    push_n("ch0_dropped", 2, 3'b001, '0);
    check_cycles(2);
    en = 3'b111;
    push_pat("ch0_restart", 0, 3, 2, 1);
    check_cycles(5);

    // Invalid channel write changes nothing; all channels restart together.
    en = '0;
    push_n("all_off", 1, '1, '0);
    check_cycles(1);
    wr(3, 7, 7);
    push_n("wr_invalid", 1, '1, '0);
    check_cycles(1);
    wr_en = 1'b0;
    en = '1;
    for (int k = 0; k < 6; k++) push_all("all_run", k, '0);
    check_cycles(6);
    wr(0, 5, 5);
    push_all("all_wr_ch0", 6, '0);
    check_cycles(1);
    wr_en = 1'b0;
    push_all("all_pend_ch0", 7, 3'b001);
    check_cycles(1);

    // Asynchronous reset mid-period with an update pending.
    #2;
    rst = 1'b1;
    #1;
    push("async_rst", '1, '0, '0, '0);
    check_now();
    @(posedge clk); #1;
    push("rst_held", '1, '0, '0, '0);
    check_now();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
